// File: rtl/psum_accum_pingpong.sv
// Ping-pong partial-sum accumulator: sums psum beats over ciGroup*kx*ky passes per wo, then drains each tile
// quantised (shift, ReLU, saturate) over ready/valid; entries are registered and hold while I_data_rdy is low.
module psum_accum_pingpong #(
    parameter int CH_OUT     = 32,
    parameter int PIX        = 8,
    parameter int PSUM_W     = 24,
    parameter int ACC_W      = 32,
    parameter int OWIDTH     = 8,
    parameter int DEPTHWIDTH = 9,
    parameter int KWIDTH     = 4
) (
    input  logic                           I_clk,
    input  logic                           I_rst_n,
    input  logic                           I_start,
    input  logic [DEPTHWIDTH-1:0]          I_ciGroup,
    input  logic [KWIDTH-1:0]              I_kx,
    input  logic [KWIDTH-1:0]              I_ky,
    input  logic [DEPTHWIDTH-1:0]          I_woGroup,
    input  logic [DEPTHWIDTH-1:0]          I_coGroup,
    input  logic [4:0]                     I_shift,
    input  logic                           I_relu_en,
    input  logic [PSUM_W*CH_OUT*PIX-1:0]   I_psum,
    input  logic                           I_psum_dv,
    output logic                           O_in_rdy,
    output logic [OWIDTH*CH_OUT*PIX-1:0]   O_data,
    output logic                           O_data_dv,
    input  logic                           I_data_rdy,
    output logic                           O_busy,
    output logic                           O_done,
    output logic                           O_err
);
    localparam int LANES = CH_OUT * PIX;
    localparam int PW    = 2 * KWIDTH + DEPTHWIDTH;
    localparam int AW    = DEPTHWIDTH + 1;
    localparam logic signed [ACC_W-1:0] QMAX = ACC_W'((1 << (OWIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] QMIN = ACC_W'(-(1 << (OWIDTH - 1)));

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;
    typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL, BK_DRAINING} bank_t;

    state_t                   state_q, state_d;
    bank_t                    bank_q [2];
    bank_t                    bank_d [2];
    logic [DEPTHWIDTH-1:0]    wo_cfg_q, wo_cfg_d, co_cfg_q, co_cfg_d;
    logic [PW-1:0]            p_cfg_q, p_cfg_d;
    logic [4:0]               shift_q, shift_d;
    logic                     relu_q, relu_d;
    logic [PW-1:0]            pass_q, pass_d;
    logic [DEPTHWIDTH-1:0]    fwo_q, fwo_d, dwo_q, dwo_d;
    logic                     fptr_q, fptr_d, dptr_q, dptr_d;
    logic [DEPTHWIDTH-1:0]    filled_q, filled_d, drained_q, drained_d;
    logic [OWIDTH*LANES-1:0]  dat_q, dat_d;
    logic                     dv_q, dv_d, err_q, err_d;

    logic [LANES*ACC_W-1:0]   mem_q [2**AW];

    logic [PW-1:0]            p_prod;
    logic                     fill_open, in_rdy, beat;
    logic                     drain_act, rd_more, xfer, load, drain_last;
    logic [AW-1:0]            fill_addr, drain_addr;
    logic [LANES*ACC_W-1:0]   fill_old, wr_dat, drain_word;
    logic [OWIDTH*LANES-1:0]  q_dat;

    function automatic logic [OWIDTH-1:0] quant(input logic [ACC_W-1:0] acc,
                                                input logic [4:0] sh, input logic relu);
        logic signed [ACC_W-1:0] v;
        v = $signed(acc) >>> sh;
        if (relu && (v < 0)) v = '0;
        if (v > QMAX) return QMAX[OWIDTH-1:0];
        if (v < QMIN) return QMIN[OWIDTH-1:0];
        return v[OWIDTH-1:0];
    endfunction

    assign p_prod    = PW'(I_ciGroup) * PW'(I_kx) * PW'(I_ky);
    assign fill_open = (bank_q[fptr_q] == BK_EMPTY) || (bank_q[fptr_q] == BK_FILLING);
    assign in_rdy    = (state_q == ST_RUN) && fill_open && (filled_q < co_cfg_q);
    assign beat      = I_psum_dv && in_rdy;
    assign fill_addr = {fptr_q, fwo_q};
    assign fill_old  = mem_q[fill_addr];

    // Drain side: dwo_q is the next entry to load; the tile ends on the transfer of the last loaded entry.
    assign drain_act  = (bank_q[dptr_q] == BK_DRAINING);
    assign rd_more    = (dwo_q != wo_cfg_q);
    assign xfer       = dv_q && I_data_rdy;
    assign load       = drain_act && rd_more && (!dv_q || I_data_rdy);
    assign drain_last = drain_act && xfer && !rd_more;
    assign drain_addr = {dptr_q, dwo_q};
    assign drain_word = mem_q[drain_addr];

    always_comb begin
        wr_dat = '0;
        q_dat  = '0;
        for (int k = 0; k < LANES; k++) begin
            wr_dat[k*ACC_W +: ACC_W] =
                {{(ACC_W-PSUM_W){I_psum[k*PSUM_W+PSUM_W-1]}}, I_psum[k*PSUM_W +: PSUM_W]}
                + ((pass_q == '0) ? '0 : fill_old[k*ACC_W +: ACC_W]);
            q_dat[k*OWIDTH +: OWIDTH] = quant(drain_word[k*ACC_W +: ACC_W], shift_q, relu_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wo_cfg_d  = wo_cfg_q;
        co_cfg_d  = co_cfg_q;
        p_cfg_d   = p_cfg_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        pass_d    = pass_q;
        fwo_d     = fwo_q;
        dwo_d     = dwo_q;
        fptr_d    = fptr_q;
        dptr_d    = dptr_q;
        filled_d  = filled_q;
        drained_d = drained_q;
        dat_d     = dat_q;
        dv_d      = dv_q;
        err_d     = err_q;

        if (beat) begin
            if (bank_q[fptr_q] == BK_EMPTY) bank_d[fptr_q] = BK_FILLING;
            if (fwo_q == wo_cfg_q - DEPTHWIDTH'(1)) begin
                fwo_d = '0;
                if (pass_q == p_cfg_q - PW'(1)) begin
                    pass_d         = '0;
                    bank_d[fptr_q] = BK_FULL;
                    filled_d       = filled_q + DEPTHWIDTH'(1);
                    fptr_d         = ~fptr_q;
                end else begin
                    pass_d = pass_q + PW'(1);
                end
            end else begin
                fwo_d = fwo_q + DEPTHWIDTH'(1);
            end
        end

        if (load) begin
            dat_d = q_dat;
            dv_d  = 1'b1;
            dwo_d = dwo_q + DEPTHWIDTH'(1);
        end else if (xfer) begin
            dv_d = 1'b0;
        end

        // Handing over to the other bank on the last transfer keeps the output gap to one cycle.
        if (drain_last) begin
            bank_d[dptr_q] = BK_EMPTY;
            drained_d      = drained_q + DEPTHWIDTH'(1);
            dptr_d         = ~dptr_q;
            dwo_d          = '0;
            if (bank_q[~dptr_q] == BK_FULL) bank_d[~dptr_q] = BK_DRAINING;
        end else if (!drain_act && (bank_q[dptr_q] == BK_FULL)) begin
            bank_d[dptr_q] = BK_DRAINING;
        end

        case (state_q)
            ST_IDLE: begin
                if (I_start) begin
                    wo_cfg_d  = I_woGroup;
                    co_cfg_d  = I_coGroup;
                    p_cfg_d   = p_prod;
                    shift_d   = I_shift;
                    relu_d    = I_relu_en;
                    pass_d    = '0;
                    fwo_d     = '0;
                    dwo_d     = '0;
                    fptr_d    = 1'b0;
                    dptr_d    = 1'b0;
                    filled_d  = '0;
                    drained_d = '0;
                    bank_d[0] = BK_EMPTY;
                    bank_d[1] = BK_EMPTY;
                    err_d     = 1'b0;
                    if ((p_prod == '0) || (I_woGroup == '0) || (I_coGroup == '0)) state_d = ST_FIN;
                    else state_d = ST_RUN;
                end
            end
            ST_RUN:  if (drained_d == co_cfg_q) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (I_psum_dv && !in_rdy) err_d = 1'b1;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= ST_IDLE;
            bank_q[0] <= BK_EMPTY;
            bank_q[1] <= BK_EMPTY;
            wo_cfg_q  <= '0;
            co_cfg_q  <= '0;
            p_cfg_q   <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            pass_q    <= '0;
            fwo_q     <= '0;
            dwo_q     <= '0;
            fptr_q    <= 1'b0;
            dptr_q    <= 1'b0;
            filled_q  <= '0;
            drained_q <= '0;
            dat_q     <= '0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wo_cfg_q  <= wo_cfg_d;
            co_cfg_q  <= co_cfg_d;
            p_cfg_q   <= p_cfg_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            pass_q    <= pass_d;
            fwo_q     <= fwo_d;
            dwo_q     <= dwo_d;
            fptr_q    <= fptr_d;
            dptr_q    <= dptr_d;
            filled_q  <= filled_d;
            drained_q <= drained_d;
            dat_q     <= dat_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
        end
    end

    // Accumulator contents carry no reset value.
    always_ff @(posedge I_clk) begin
        if (beat) mem_q[fill_addr] <= wr_dat;
    end

    assign O_in_rdy  = in_rdy;
    assign O_data    = dat_q;
    assign O_data_dv = dv_q;
    assign O_busy    = (state_q != ST_IDLE);
    assign O_done    = (state_q == ST_FIN);
    assign O_err     = err_q;
endmodule

// File: tb/tb_psum_accum_pingpong.sv
// Bench for psum_accum_pingpong: table vectors, hand sequences and random layers against a tile/array model.
module tb_psum_accum_pingpong;
    localparam int LN  = 4;
    localparam int PSW = 24;
    localparam int OW  = 8;
    localparam int DW  = 4;
    localparam int KW  = 4;
    localparam int QHI = (1 << (OW - 1)) - 1;
    localparam int QLO = -(1 << (OW - 1));

    typedef logic [LN*PSW-1:0] psum_t;
    typedef logic [LN*OW-1:0]  out_t;
    typedef struct {
        int ps[4];
        int sh;
        int relu;
        int ex[4];
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, start, psum_dv, data_rdy, relu_en;
    logic [DW-1:0] ci_g, wo_g, co_g;
    logic [KW-1:0] kx, ky;
    logic [4:0]    shift;
    psum_t         psum;
    logic          in_rdy, data_dv, busy, done, err;
    out_t          data;

    int    total = 0;
    int    bad   = 0;
    psum_t beat_q[$];
    out_t  exp_q[$];
    vec_t  tbl[6];

    always #5 clk = ~clk;

    psum_accum_pingpong #(
        .CH_OUT(2), .PIX(2), .PSUM_W(PSW), .ACC_W(32), .OWIDTH(OW), .DEPTHWIDTH(DW), .KWIDTH(KW)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .I_ciGroup(ci_g), .I_kx(kx), .I_ky(ky),
        .I_woGroup(wo_g), .I_coGroup(co_g), .I_shift(shift), .I_relu_en(relu_en), .I_psum(psum),
        .I_psum_dv(psum_dv), .O_in_rdy(in_rdy), .O_data(data), .O_data_dv(data_dv),
        .I_data_rdy(data_rdy), .O_busy(busy), .O_done(done), .O_err(err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic psum_t pk_ps(input int a, input int b, input int c, input int d);
        int v[4];
        psum_t r;
        v = '{a, b, c, d};
        r = '0;
        for (int k = 0; k < LN; k++) r[k*PSW +: PSW] = v[k][PSW-1:0];
        return r;
    endfunction

    function automatic out_t pk_o(input int a, input int b, input int c, input int d);
        int v[4];
        out_t r;
        v = '{a, b, c, d};
        r = '0;
        for (int k = 0; k < LN; k++) r[k*OW +: OW] = v[k][OW-1:0];
        return r;
    endfunction

    function automatic int rs();
        return int'($urandom_range(0, 1200)) - 600;
    endfunction

    // Reference: beat i belongs to tile i/(P*wo), entry (i mod P*wo) mod wo; sums wrap as 32-bit ints.
    task automatic model(input int ci, input int kxv, input int kyv, input int wo, input int co,
                         input int sh, input int relu);
        int p, t, r, w, v;
        int acc[];
        out_t o;
        p   = ci * kxv * kyv;
        acc = new[co * wo * LN];
        foreach (acc[i]) acc[i] = 0;
        for (int i = 0; i < beat_q.size(); i++) begin
            t = i / (p * wo);
            r = i % (p * wo);
            w = r % wo;
            for (int k = 0; k < LN; k++)
                acc[(t*wo + w)*LN + k] += int'($signed(beat_q[i][k*PSW +: PSW]));
        end
        exp_q.delete();
        for (int e = 0; e < co * wo; e++) begin
            o = '0;
            for (int k = 0; k < LN; k++) begin
                v = acc[e*LN + k] >>> sh;
                if (relu != 0 && v < 0) v = 0;
                if (v > QHI) v = QHI;
                if (v < QLO) v = QLO;
                o[k*OW +: OW] = v[OW-1:0];
            end
            exp_q.push_back(o);
        end
    endtask

    // Starts a layer, feeds beat_q, drains and compares against exp_q. For the first 'hold' cycles ready is held low.
    task automatic run_layer(input int ci, input int kxv, input int kyv, input int wo, input int co,
                             input int sh, input int relu, input int rdy_all, input int dv_full,
                             input int hold, input int hold_beats, input string tag);
        int   nb, bi, cyc, last_x, done_c, stab_bad;
        logic prev_stall, r;
        out_t prev;
        nb = beat_q.size();
        bi = 0; cyc = 0; last_x = -10; done_c = -1; stab_bad = 0; prev_stall = 1'b0; prev = '0;
        @(negedge clk);
        ci_g = DW'(ci); kx = KW'(kxv); ky = KW'(kyv); wo_g = DW'(wo); co_g = DW'(co);
        shift = 5'(sh); relu_en = (relu != 0); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        while (cyc < 3000) begin
            if (done) begin
                done_c = cyc;
                break;
            end
            if (prev_stall && (data !== prev || !data_dv)) stab_bad++;
            if (cyc < hold) r = 1'b0;
            else if (rdy_all != 0) r = 1'b1;
            else r = ($urandom_range(0, 3) != 0);
            if (hold > 0 && cyc == hold) begin
                chk({tag, "_hold_inrdy"}, in_rdy, 0);
                chk({tag, "_hold_beats"}, bi, hold_beats);
                chk({tag, "_hold_dv"}, data_dv, 1);
                chk({tag, "_hold_stable"}, stab_bad, 0);
            end
            if (data_dv && r) begin
                if (exp_q.size() == 0) chk({tag, "_extra_out"}, 1, 0);
                else chk({tag, "_out"}, data, exp_q.pop_front());
                last_x = cyc;
            end
            prev_stall = data_dv && !r;
            prev       = data;
            data_rdy   = r;
            if (bi < nb && in_rdy && (dv_full != 0 || $urandom_range(0, 2) != 0)) begin
                psum    = beat_q[bi];
                psum_dv = 1'b1;
                bi++;
            end else begin
                psum_dv = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        psum_dv  = 1'b0;
        data_rdy = 1'b0;
        chk({tag, "_done_seen"}, (done_c >= 0), 1);
        chk({tag, "_done_lat"}, done_c - last_x, 1);
        chk({tag, "_missing"}, exp_q.size(), 0);
        chk({tag, "_beats"}, bi, nb);
        chk({tag, "_stable"}, stab_bad, 0);
        chk({tag, "_err"}, err, 0);
        @(negedge clk);
        chk({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    task automatic rand_run(input string tag);
        int ci, kxv, kyv, wo, co, sh, relu, n;
        ci = $urandom_range(1, 2); kxv = $urandom_range(1, 3); kyv = $urandom_range(1, 2);
        wo = $urandom_range(1, 5); co = $urandom_range(1, 4);
        sh = $urandom_range(0, 5); relu = $urandom_range(0, 1);
        n  = ci * kxv * kyv * wo * co;
        beat_q.delete();
        for (int i = 0; i < n; i++) beat_q.push_back(pk_ps(rs(), rs(), rs(), rs()));
        model(ci, kxv, kyv, wo, co, sh, relu);
        run_layer(ci, kxv, kyv, wo, co, sh, relu, 0, 0, 0, 0, tag);
    endtask

    initial begin
        int   bi;
        logic dv_seen;
        tbl[0] = '{ps: '{-20, 300, -300, 100}, sh: 0, relu: 0, ex: '{-20, 127, -128, 100}};
        tbl[1] = '{ps: '{-20, 300, -300, 100}, sh: 0, relu: 1, ex: '{0, 127, 0, 100}};
        tbl[2] = '{ps: '{5, 7, -1, 0},         sh: 0, relu: 0, ex: '{5, 7, -1, 0}};
        tbl[3] = '{ps: '{-7, 7, 1000, -1000},  sh: 2, relu: 0, ex: '{-2, 1, 127, -128}};
        tbl[4] = '{ps: '{128, -129, 127, -128}, sh: 0, relu: 0, ex: '{127, -128, 127, -128}};
        tbl[5] = '{ps: '{-1, 255, 512, -513},  sh: 1, relu: 1, ex: '{0, 127, 127, 0}};

        rst_n = 1'b0; start = 1'b0; psum_dv = 1'b0; data_rdy = 1'b0; relu_en = 1'b0;
        ci_g = '0; wo_g = '0; co_g = '0; kx = '0; ky = '0; shift = '0; psum = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_dv", data_dv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_inrdy", in_rdy, 0);
        chk("rst_data", data, 0);

        beat_q.delete(); exp_q.delete();
        beat_q.push_back(pk_ps(5, 5, 5, 5)); beat_q.push_back(pk_ps(7, 7, 7, 7));
        exp_q.push_back(pk_o(5, 5, 5, 5));   exp_q.push_back(pk_o(7, 7, 7, 7));
        run_layer(1, 1, 1, 2, 1, 0, 0, 1, 1, 0, 0, "two_wo");

        for (int s = 0; s < 2; s++) begin
            beat_q.delete(); exp_q.delete();
            for (int i = 0; i < 9; i++) beat_q.push_back(pk_ps(10, 10, 10, 10));
            if (s == 0) exp_q.push_back(pk_o(90, 90, 90, 90));
            else exp_q.push_back(pk_o(22, 22, 22, 22));
            run_layer(1, 3, 3, 1, 1, 2 * s, 0, 1, 1, 0, 0, (s == 0) ? "k3x3_sh0" : "k3x3_sh2");
        end

        for (int i = 0; i < 6; i++) begin
            beat_q.delete(); exp_q.delete();
            beat_q.push_back(pk_ps(tbl[i].ps[0], tbl[i].ps[1], tbl[i].ps[2], tbl[i].ps[3]));
            exp_q.push_back(pk_o(tbl[i].ex[0], tbl[i].ex[1], tbl[i].ex[2], tbl[i].ex[3]));
            run_layer(1, 1, 1, 1, 1, tbl[i].sh, tbl[i].relu, 0, 1, 0, 0, $sformatf("tbl%0d", i));
        end

        beat_q.delete();
        for (int i = 0; i < 12; i++) beat_q.push_back(pk_ps(i*3 - 10, i*20 - 100, -i, i));
        model(1, 1, 1, 4, 3, 0, 0);
        run_layer(1, 1, 1, 4, 3, 0, 0, 1, 1, 40, 8, "hold");

        @(negedge clk);
        ci_g = 4'd1; kx = 4'd1; ky = 4'd1; wo_g = 4'd0; co_g = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dv_seen = data_dv;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        @(negedge clk);
        dv_seen = dv_seen | data_dv;
        chk("zero_done_end", {busy, done}, 2'b00);
        chk("zero_no_dv", dv_seen, 0);
        psum_dv = 1'b1;
        @(negedge clk);
        psum_dv = 1'b0;
        chk("idle_err", err, 1);

        for (int i = 0; i < 5; i++) rand_run($sformatf("rnd%0d", i));

        beat_q.delete();
        for (int i = 0; i < 6; i++) beat_q.push_back(pk_ps(i + 1, -(i + 1), 10 * i, 3));
        @(negedge clk);
        ci_g = 4'd1; kx = 4'd1; ky = 4'd1; wo_g = 4'd3; co_g = 4'd2; shift = '0; relu_en = 1'b0;
        data_rdy = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bi = 0;
        for (int c = 0; c < 100 && !(bi == 6 && data_dv && !in_rdy); c++) begin
            if (bi < 6 && in_rdy) begin
                psum = beat_q[bi]; psum_dv = 1'b1; bi++;
            end else begin
                psum_dv = 1'b0;
            end
            @(negedge clk);
        end
        psum_dv = 1'b0;
        chk("rst_setup", (bi == 6 && data_dv && !in_rdy), 1);
        psum_dv = 1'b1;
        @(negedge clk);
        psum_dv = 1'b0;
        chk("stall_err", err, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dv", data_dv, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_done", done, 0);

        rand_run("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
